usb_extbus_master: RTL and testbench

Bus initiator for the SAM3U-style 8-bit external parallel bus: USB_D, USB_Addr, RDn, WRn, CEn and ALEn. It is the opposite end of the FPGA register-interface responder. It converts a command handshake into address-latch and burst read/write strobe cycles. Used in bench harnesses, and as the master side when one FPGA drives another FPGA's register map.

---
 rtl/usb_extbus_master_pkg.sv | 31 +++
 rtl/usb_extbus_master_if.sv | 28 ++
 rtl/usb_extbus_master_phase_timer.sv | 27 ++
 rtl/usb_extbus_master.sv | 221 ++++++++++++++++++++++
 tb/tb_usb_extbus_master.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_extbus_master_pkg.sv
// Shared types and constants for the SAM3U-style external bus initiator.
package usbm_pkg;

    localparam int unsigned PH_W         = 4;
    localparam int unsigned LEN_W        = 16;
    localparam int unsigned T_SETUP_DEF  = 2;
    localparam int unsigned T_STROBE_DEF = 3;
    localparam int unsigned T_HOLD_DEF   = 1;
    localparam int unsigned TIMEOUT_DEF  = 255;

    typedef logic [PH_W-1:0]  phase_t;
    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ASETUP,
        S_ALE,
        S_AHOLD,
        S_WAITW,
        S_DSETUP,
        S_STROBE,
        S_DHOLD,
        S_DONE
    } usbm_state_e;

    // The phase timer signals done on its last count, so a phase of N cycles loads N-1.
    function automatic phase_t phase_load(input int unsigned cycles);
        return phase_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/usb_extbus_master_if.sv
// Command / write-data / read-data / status handshake of the bus initiator.
// master: the side issuing commands; slave: the usb_extbus_master itself.
interface usb_extbus_master_if import usbm_pkg::*; ;

    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [7:0]  cmd_addr_i;
    len_t        cmd_len_i;
    logic [7:0]  wdata_i;
    logic        wdata_valid_i;
    logic        wdata_ready_o;
    logic [7:0]  rdata_o;
    logic        rdata_valid_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i, wdata_i, wdata_valid_i,
        input  cmd_ready_o, wdata_ready_o, rdata_o, rdata_valid_o, busy_o, err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i, wdata_i, wdata_valid_i,
        output cmd_ready_o, wdata_ready_o, rdata_o, rdata_valid_o, busy_o, err_o
    );

endinterface

// File: rtl/usb_extbus_master_phase_timer.sv
// Loadable down-counter timing each bus phase; done while the count sits at zero.
module usbm_phase_timer
    import usbm_pkg::*;
(
    input  logic   clk,
    input  logic   reset_i,
    input  logic   load_i,
    input  phase_t load_val_i,
    output logic   done_o
);

    phase_t cnt_q;

    // Load on phase entry, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - phase_t'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/usb_extbus_master.sv
// Initiator for the 8-bit external parallel bus (address latch + burst strobes).
// Optional stall timeout in WAITW built when USBM_TIMEOUT_EN is defined.
module usb_extbus_master
    import usbm_pkg::*;
#(
    parameter int unsigned T_SETUP     = T_SETUP_DEF,
    parameter int unsigned T_STROBE    = T_STROBE_DEF,
    parameter int unsigned T_HOLD      = T_HOLD_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset_i,
    usb_extbus_master_if.slave  cmd_if,
    input  logic [7:0]          usb_d_i,
    output logic [7:0]          usb_d_o,
    output logic                usb_d_oe_o,
    output logic [7:0]          usb_addr_o,
    output logic                usb_rdn_o,
    output logic                usb_wrn_o,
    output logic                usb_cen_o,
    output logic                usb_alen_o
);

    if (T_SETUP < 1 || T_SETUP > 15 || T_STROBE < 1 || T_STROBE > 15 ||
        T_HOLD < 1 || T_HOLD > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("usb_extbus_master: parameter out of range");
    end

    usbm_state_e state_q, state_d;
    logic        wr_q, wr_d;
    len_t        rem_q, rem_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        oe_q, oe_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        wready_q, wready_d;
    logic        rdn_q, rdn_d, wrn_q, wrn_d, cen_q, cen_d, alen_q, alen_d;
    logic        ld;
    phase_t      ld_val;
    logic        ph_done;
    logic        accept;
    logic        timeout;

    usbm_phase_timer u_timer (
        .clk        (clk),
        .reset_i    (reset_i),
        .load_i     (ld),
        .load_val_i (ld_val),
        .done_o     (ph_done)
    );

`ifdef USBM_TIMEOUT_EN
    len_t stall_q;
    logic err_q;

    // Count consecutive WAITW cycles; restarts whenever WAITW is left.
    always_ff @(posedge clk) begin
        if (reset_i || state_q != S_WAITW) begin
            stall_q <= '0;
        end else if (stall_q != '1) begin
            stall_q <= stall_q + len_t'(1);
        end
    end

    // Sticky timeout flag, cleared by the next accepted command.
    always_ff @(posedge clk) begin
        if (reset_i || accept) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign cmd_if.err_o = err_q;
`else
    assign cmd_if.err_o = 1'b0;
`endif

    // Next state, phase-timer loads and registered bus outputs derived from the next state.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        ld       = 1'b0;
        ld_val   = phase_load(T_SETUP);
        accept   = 1'b0;
        timeout  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_if.cmd_valid_i) begin
                    accept  = 1'b1;
                    wr_d    = cmd_if.cmd_write_i;
                    addr_d  = cmd_if.cmd_addr_i;
                    rem_d   = (cmd_if.cmd_len_i == '0) ? len_t'(1) : cmd_if.cmd_len_i;
                    state_d = S_ASETUP;
                    ld      = 1'b1;
                end
            end
            S_ASETUP: if (ph_done) begin
                state_d = S_ALE;
                ld      = 1'b1;
                ld_val  = phase_load(T_STROBE);
            end
            S_ALE: if (ph_done) begin
                state_d = S_AHOLD;
                ld      = 1'b1;
                ld_val  = phase_load(T_HOLD);
            end
            S_AHOLD: if (ph_done) begin
                state_d = wr_q ? S_WAITW : S_DSETUP;
                ld      = !wr_q;
            end
            S_WAITW: begin
                if (cmd_if.wdata_valid_i) begin
                    dout_d  = cmd_if.wdata_i;
                    oe_d    = 1'b1;
                    state_d = S_DSETUP;
                    ld      = 1'b1;
                end
`ifdef USBM_TIMEOUT_EN
                else if (stall_q == len_t'(TIMEOUT_CYC - 1)) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_DSETUP: if (ph_done) begin
                state_d = S_STROBE;
                ld      = 1'b1;
                ld_val  = phase_load(T_STROBE);
            end
            S_STROBE: if (ph_done) begin
                state_d = S_DHOLD;
                ld      = 1'b1;
                ld_val  = phase_load(T_HOLD);
                if (!wr_q) begin
                    rdata_d  = usb_d_i;
                    rvalid_d = 1'b1;
                end
            end
            S_DHOLD: if (ph_done) begin
                if (rem_q != '0) begin
                    rem_d = rem_q - len_t'(1);
                end
                if (rem_q > len_t'(1)) begin
                    state_d = wr_q ? S_WAITW : S_DSETUP;
                    ld      = !wr_q;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes and chip enable follow the state being entered, so they are registered
        // together with it; CEn rises on the edge that leaves DONE.
        alen_d   = (state_d != S_ALE);
        rdn_d    = !(state_d == S_STROBE && !wr_d);
        wrn_d    = !(state_d == S_STROBE && wr_d);
        cen_d    = (state_d == S_IDLE);
        wready_d = (state_d == S_WAITW);
        if (state_d == S_IDLE || state_d == S_DONE) begin
            oe_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            rem_q    <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            oe_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
            rdn_q    <= 1'b1;
            wrn_q    <= 1'b1;
            cen_q    <= 1'b1;
            alen_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wready_q <= wready_d;
            rdn_q    <= rdn_d;
            wrn_q    <= wrn_d;
            cen_q    <= cen_d;
            alen_q   <= alen_d;
        end
    end

    assign cmd_if.cmd_ready_o   = (state_q == S_IDLE);
    assign cmd_if.busy_o        = (state_q != S_IDLE);
    assign cmd_if.wdata_ready_o = wready_q;
    assign cmd_if.rdata_o       = rdata_q;
    assign cmd_if.rdata_valid_o = rvalid_q;
    assign usb_d_o              = dout_q;
    assign usb_d_oe_o           = oe_q;
    assign usb_addr_o           = addr_q;
    assign usb_rdn_o            = rdn_q;
    assign usb_wrn_o            = wrn_q;
    assign usb_cen_o            = cen_q;
    assign usb_alen_o           = alen_q;

endmodule

// File: tb/tb_usb_extbus_master.sv
// Randomized bench for usb_extbus_master with a bus responder and a transaction-level model.
// Build with USBM_TIMEOUT_EN to exercise the WAITW timeout.
module tb_usb_extbus_master;
    import usbm_pkg::*;

    localparam int unsigned TS  = 2;
    localparam int unsigned TST = 3;
    localparam int unsigned TH  = 1;
`ifdef USBM_TIMEOUT_EN
    localparam int unsigned TO  = 8;
`else
    localparam int unsigned TO  = 255;
`endif

    logic       clk = 1'b0;
    logic       reset_i;
    logic [7:0] usb_d_i, usb_d_o, usb_addr_o;
    logic       usb_d_oe_o, usb_rdn_o, usb_wrn_o, usb_cen_o, usb_alen_o;

    usb_extbus_master_if bif ();

    usb_extbus_master #(
        .T_SETUP     (TS),
        .T_STROBE    (TST),
        .T_HOLD      (TH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .reset_i    (reset_i),
        .cmd_if     (bif),
        .usb_d_i    (usb_d_i),
        .usb_d_o    (usb_d_o),
        .usb_d_oe_o (usb_d_oe_o),
        .usb_addr_o (usb_addr_o),
        .usb_rdn_o  (usb_rdn_o),
        .usb_wrn_o  (usb_wrn_o),
        .usb_cen_o  (usb_cen_o),
        .usb_alen_o (usb_alen_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor / responder state
    int         ale_cnt, wr_cnt, rd_cnt, width_bad, turn_bad, cen_low, addr_bad;
    int         wr_oe_bad, dstab_bad, read_oe;
    logic [7:0] ale_addr, cur_addr, wr_last;
    logic [7:0] resp_base;
    int         resp_idx;
    bit         mon_wr;
    logic [7:0] wrq[$];
    logic [7:0] rvq[$];

    // Write-data feeder state
    logic [7:0] fq[$];
    int         fdq[$];
    int         cur_delay;
    bit         pend_hs;
    int         hs_cnt;

    task automatic clr_mon();
        ale_cnt = 0; wr_cnt = 0; rd_cnt = 0; width_bad = 0; turn_bad = 0;
        cen_low = 0; addr_bad = 0; wr_oe_bad = 0; dstab_bad = 0; read_oe = 0;
        hs_cnt = 0; resp_idx = 0;
        wrq.delete();
        rvq.delete();
    endtask

    // Monitor and read responder: samples on the falling edge.
    initial begin
        int  ale_w, wr_w, rd_w;
        bit  p_alen, p_wrn, p_rdn;
        usb_d_i = '0;
        ale_w = 0; wr_w = 0; rd_w = 0;
        p_alen = 1'b1; p_wrn = 1'b1; p_rdn = 1'b1;
        forever begin
            @(negedge clk);
            if (!usb_alen_o) begin
                if (p_alen) begin ale_cnt++; ale_addr = usb_addr_o; end
                ale_w++;
            end else if (!p_alen) begin
                if (ale_w != int'(TST)) width_bad++;
                ale_w = 0;
            end
            if (!usb_wrn_o) begin
                if (p_wrn) begin
                    wr_cnt++;
                    wr_last = usb_d_o;
                    wrq.push_back(usb_d_o);
                end
                if (!usb_d_oe_o) wr_oe_bad++;
                if (usb_d_o != wr_last) dstab_bad++;
                wr_w++;
            end else if (!p_wrn) begin
                if (wr_w != int'(TST)) width_bad++;
                wr_w = 0;
            end
            if (!usb_rdn_o) begin
                if (p_rdn) begin
                    rd_cnt++;
                    usb_d_i = resp_base + 8'(resp_idx);
                    resp_idx++;
                end
                rd_w++;
            end else if (!p_rdn) begin
                if (rd_w != int'(TST)) width_bad++;
                rd_w = 0;
            end
            if (usb_d_oe_o && !usb_rdn_o) turn_bad++;
            if (!mon_wr && usb_d_oe_o) read_oe++;
            if (!usb_cen_o) begin
                cen_low++;
                if (usb_addr_o != cur_addr) addr_bad++;
            end
            if (bif.rdata_valid_o) rvq.push_back(bif.rdata_o);
            p_alen = usb_alen_o; p_wrn = usb_wrn_o; p_rdn = usb_rdn_o;
        end
    end

    // Write-data feeder: each byte is withheld for its delay counted in cycles where ready is high.
    initial begin
        bif.wdata_valid_i = 1'b0;
        bif.wdata_i       = '0;
        cur_delay = 0;
        pend_hs   = 1'b0;
        forever begin
            @(negedge clk);
            if (pend_hs && fq.size() > 0) begin
                void'(fq.pop_front());
                void'(fdq.pop_front());
                hs_cnt++;
                if (fdq.size() > 0) cur_delay = fdq[0];
            end
            if (fq.size() == 0) begin
                bif.wdata_valid_i = 1'b0;
            end else if (cur_delay > 0) begin
                bif.wdata_valid_i = 1'b0;
                if (bif.wdata_ready_o) cur_delay--;
            end else begin
                bif.wdata_valid_i = 1'b1;
                bif.wdata_i       = fq[0];
            end
            pend_hs = bif.wdata_valid_i && bif.wdata_ready_o;
        end
    end

    task automatic issue(input bit wr, input logic [7:0] addr, input int len);
        @(negedge clk);
        check_eq("ready_before_cmd", {31'd0, bif.cmd_ready_o}, 32'd1);
        bif.cmd_valid_i = 1'b1;
        bif.cmd_write_i = wr;
        bif.cmd_addr_i  = addr;
        bif.cmd_len_i   = 16'(len);
        @(negedge clk);
        bif.cmd_valid_i = 1'b0;
        check_eq("busy_after_accept", {31'd0, bif.busy_o}, 32'd1);
        check_eq("err_clear_on_accept", {31'd0, bif.err_o}, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (bif.busy_o && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) check_eq({tag, "_done_timeout"}, 32'(cyc), 32'd0);
    endtask

    // One full command checked against the transaction model.
    // fix >= 0 pins first write byte / responder base; stall1 >= 0 pins delay of byte index 1.
    task automatic run_cmd(input string tag, input bit wr, input logic [7:0] addr, input int len,
                           input int dmax, input int stall1, input int fix);
        int         n, stall_sum, exp_cen;
        logic [7:0] eb[$];
        n = (len == 0) ? 1 : len;
        stall_sum = 0;
        clr_mon();
        mon_wr    = wr;
        cur_addr  = addr;
        resp_base = (fix >= 0) ? 8'(fix) : 8'($urandom);
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                int         d;
                b = (fix >= 0) ? 8'(fix + i) : 8'($urandom);
                d = (i == 1 && stall1 >= 0) ? stall1 : int'($urandom_range(dmax, 0));
                eb.push_back(b);
                fq.push_back(b);
                fdq.push_back(d);
                stall_sum += d;
            end
            cur_delay = fdq[0];
        end
        issue(wr, addr, len);
        wait_idle(tag);
        exp_cen = int'(TS + TST + TH) + n * int'(TS + TST + TH) + (wr ? n + stall_sum : 0) + 1;
        check_eq({tag, "_ale_pulses"}, 32'(ale_cnt), 32'd1);
        check_eq({tag, "_ale_addr"}, {24'd0, ale_addr}, {24'd0, addr});
        check_eq({tag, "_addr_stable"}, 32'(addr_bad), 32'd0);
        check_eq({tag, "_strobe_width"}, 32'(width_bad), 32'd0);
        check_eq({tag, "_turnaround"}, 32'(turn_bad), 32'd0);
        check_eq({tag, "_cen_low_cycles"}, 32'(cen_low), 32'(exp_cen));
        check_eq({tag, "_err"}, {31'd0, bif.err_o}, 32'd0);
        if (wr) begin
            check_eq({tag, "_wrn_pulses"}, 32'(wr_cnt), 32'(n));
            check_eq({tag, "_rdn_pulses"}, 32'(rd_cnt), 32'd0);
            check_eq({tag, "_wdata_handshakes"}, 32'(hs_cnt), 32'(n));
            check_eq({tag, "_wr_oe"}, 32'(wr_oe_bad), 32'd0);
            check_eq({tag, "_wr_data_stable"}, 32'(dstab_bad), 32'd0);
            for (int i = 0; i < n && i < wrq.size(); i++)
                check_eq({tag, "_wr_byte"}, {24'd0, wrq[i]}, {24'd0, eb[i]});
        end else begin
            check_eq({tag, "_rdn_pulses"}, 32'(rd_cnt), 32'(n));
            check_eq({tag, "_wrn_pulses"}, 32'(wr_cnt), 32'd0);
            check_eq({tag, "_rd_oe"}, 32'(read_oe), 32'd0);
            check_eq({tag, "_rvalid_count"}, 32'(rvq.size()), 32'(n));
            for (int i = 0; i < n && i < rvq.size(); i++)
                check_eq({tag, "_rd_byte"}, {24'd0, rvq[i]}, {24'd0, resp_base + 8'(i)});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i           = 1'b1;
        bif.cmd_valid_i   = 1'b0;
        bif.cmd_write_i   = 1'b0;
        bif.cmd_addr_i    = '0;
        bif.cmd_len_i     = '0;
        mon_wr            = 1'b0;
        cur_addr          = '0;
        resp_base         = '0;
        clr_mon();
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_strobes", {28'd0, usb_rdn_o, usb_wrn_o, usb_cen_o, usb_alen_o}, 32'hF);
        check_eq("rst_oe", {31'd0, usb_d_oe_o}, 32'd0);
        check_eq("rst_buses", {8'd0, usb_d_o, usb_addr_o, bif.rdata_o}, 32'd0);
        check_eq("rst_pulses", {29'd0, bif.rdata_valid_o, bif.wdata_ready_o, bif.err_o}, 32'd0);
        check_eq("rst_ready", {31'd0, bif.cmd_ready_o}, 32'd1);
        reset_i = 1'b0;
        @(negedge clk);

        // Directed: single write, exact latency
        run_cmd("single_wr", 1'b1, 8'h05, 1, 0, -1, 8'hA5);
        check_eq("single_wr_cen14", 32'(cen_low), 32'd14);

        // Directed: read burst of 4 with responder bytes 0x10..0x13
        run_cmd("rd_burst4", 1'b0, 8'h3C, 4, 0, -1, 8'h10);

`ifndef USBM_TIMEOUT_EN
        // Directed: write burst with a 20-cycle stall before byte 2
        run_cmd("wr_stall", 1'b1, 8'h21, 2, 0, 20, -1);
`endif

        // Directed: len 0 treated as one byte
        run_cmd("wr_len0", 1'b1, 8'h77, 0, 0, -1, -1);

        // Directed: reset in the first STROBE cycle of a read
        begin
            int cyc = 0;
            clr_mon();
            mon_wr = 1'b0; cur_addr = 8'h44; resp_base = 8'h90;
            issue(1'b0, 8'h44, 4);
            while (usb_rdn_o && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check_eq("rst_mid_reach_strobe", {31'd0, usb_rdn_o}, 32'd0);
            reset_i = 1'b1;
            @(negedge clk);
            check_eq("rst_mid_strobes", {28'd0, usb_rdn_o, usb_wrn_o, usb_cen_o, usb_alen_o}, 32'hF);
            check_eq("rst_mid_oe", {31'd0, usb_d_oe_o}, 32'd0);
            check_eq("rst_mid_rvalid", {31'd0, bif.rdata_valid_o}, 32'd0);
            reset_i = 1'b0;
            @(negedge clk);
            check_eq("rst_mid_ready", {31'd0, bif.cmd_ready_o}, 32'd1);
            repeat (10) @(negedge clk);
            check_eq("rst_mid_no_rdata", 32'(rvq.size()), 32'd0);
            check_eq("rst_mid_rdn_pulses", 32'(rd_cnt), 32'd1);
        end

`ifdef USBM_TIMEOUT_EN
        // Timeout: byte 2 of a 3-byte write never arrives
        begin
            clr_mon();
            mon_wr = 1'b1; cur_addr = 8'h5A;
            fq.push_back(8'h11); fdq.push_back(0);
            fq.push_back(8'h22); fdq.push_back(100000);
            fq.push_back(8'h33); fdq.push_back(0);
            cur_delay = 0;
            issue(1'b1, 8'h5A, 3);
            wait_idle("timeout");
            check_eq("timeout_err", {31'd0, bif.err_o}, 32'd1);
            check_eq("timeout_idle", {31'd0, bif.cmd_ready_o}, 32'd1);
            check_eq("timeout_wrn_pulses", 32'(wr_cnt), 32'd1);
            check_eq("timeout_cen_low", 32'(cen_low),
                     32'(2 * int'(TS + TST + TH) + 1 + int'(TO) + 1));
            fq.delete(); fdq.delete(); cur_delay = 0;
            @(negedge clk);
            // issue() checks that the accept clears err_o
            run_cmd("after_timeout", 1'b1, 8'h5B, 1, 0, -1, -1);
        end
`endif

        // Randomized commands against the transaction model
        for (int k = 0; k < 14; k++) begin
            run_cmd("rand", 1'($urandom), 8'($urandom), int'($urandom_range(5, 0)), 3, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
